// File: rtl/disp_pkg.sv
// Shared sizes and command encoding for the seven-segment text buffer controller.
// No logic; constants and types only.
// Imported by disp_buf_ctrl.
package disp_pkg;
   localparam int SLOTS = 8;
   localparam int SEG_W = 8;
   localparam int CNT_W = $clog2(SLOTS + 1);
   localparam logic [SEG_W-1:0] BLANK_SEG = 8'h00;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_PUSH,
      CMD_BKSP,
      CMD_CLR
   } cmd_e;
endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press pulse: 2-flop sync, stability debounce, rising-edge detect.
// Latency: 2 sync cycles + DEB_CYCLES stable samples, pulse registered on the accepting edge.
// No backpressure; a press is a single-cycle pulse the consumer must capture.
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   logic          sync0;
   logic          sync1;
   logic          level;
   logic [DW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync0      <= 1'b0;
         sync1      <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync0 <= btn;
         sync1 <= sync0;
         press <= 1'b0;
         // Counter tracks how long the synchronized input has disagreed with the accepted level.
         if (sync1 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == DW'(DEB_CYCLES - 1)) begin
            level      <= sync1;
            stable_cnt <= '0;
            press      <= sync1;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/disp_buf_ctrl.sv
// 8-slot seven-segment text buffer: push/backspace/clear arbitration and optional digit scan (DISP_SCAN_EN).
// Latency: push visible next cycle; button command executes the edge after its pending flag sets.
// char_ready drops for exactly one cycle while a button command is executed.
module disp_buf_ctrl #(
   parameter int SLOTS      = 8,
   parameter int SEG_W      = 8,
   parameter int DEB_CYCLES = 1_000_000,
   parameter int SCAN_DIV   = 100_000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        char_valid,
   input  logic [SEG_W-1:0]            char_seg,
   output logic                        char_ready,
   input  logic                        bksp_btn,
   input  logic                        clr_btn,
   output logic [SLOTS*SEG_W-1:0]      seg_buf,
   output logic [disp_pkg::CNT_W-1:0]  count,
   output logic                        full,
   output logic [SLOTS-1:0]            an,
   output logic [SEG_W-1:0]            seg
);
   import disp_pkg::*;

   localparam int BUF_W = SLOTS * SEG_W;

   logic             bksp_press;
   logic             clr_press;
   logic             clr_p;
   logic             bksp_p;
   logic [BUF_W-1:0] buf_q;
   logic [CNT_W-1:0] cnt_q;
   cmd_e             cmd;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_bksp_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (bksp_btn),
      .press (bksp_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (clr_btn),
      .press (clr_press)
   );

   assign char_ready = ~clr_p & ~bksp_p;
   assign seg_buf    = buf_q;
   assign count      = cnt_q;
   assign full       = (cnt_q == CNT_W'(SLOTS));

   always_comb begin
      cmd = CMD_NONE;
      if (clr_p)
         cmd = CMD_CLR;
      else if (bksp_p)
         cmd = CMD_BKSP;
      else if (char_valid && char_seg != BLANK_SEG)
         cmd = CMD_PUSH;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_p  <= 1'b0;
         bksp_p <= 1'b0;
         buf_q  <= '0;
         cnt_q  <= '0;
      end else begin
         // A press landing on a cycle whose flag is already being executed merges into that execution.
         clr_p  <= clr_p ? 1'b0 : clr_press;
         bksp_p <= (clr_p || bksp_p) ? 1'b0 : bksp_press;
         case (cmd)
            CMD_CLR: begin
               buf_q <= '0;
               cnt_q <= '0;
            end
            CMD_BKSP: begin
               if (cnt_q != '0) begin
                  buf_q <= {BLANK_SEG, buf_q[BUF_W-1:SEG_W]};
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            CMD_PUSH: begin
               buf_q <= {buf_q[BUF_W-SEG_W-1:0], char_seg};
               if (cnt_q != CNT_W'(SLOTS))
                  cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DISP_SCAN_EN
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic [DIV_W-1:0] div_q;
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         idx_q <= '0;
         an    <= '1;
         seg   <= BLANK_SEG;
      end else begin
         if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(SLOTS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
         end
         an  <= ~(SLOTS'(1) << idx_q);
         seg <= buf_q[idx_q*SEG_W +: SEG_W];
      end
   end
`else
   assign an  = '1;
   assign seg = BLANK_SEG;
`endif
endmodule

// File: tb/tb_disp_buf_ctrl.sv
// Scoreboard bench for disp_buf_ctrl: a cycle model queues expected outputs, a negedge monitor compares.
module tb_disp_buf_ctrl;
   localparam int DEB      = 4;
   localparam int SCAN_DIV = 2;

   logic        clk;
   logic        rst;
   logic        char_valid;
   logic [7:0]  char_seg;
   logic        char_ready;
   logic        bksp_btn;
   logic        clr_btn;
   logic [63:0] seg_buf;
   logic [3:0]  count;
   logic        full;
   logic [7:0]  an;
   logic [7:0]  seg;

   disp_buf_ctrl #(
      .SLOTS      (8),
      .SEG_W      (8),
      .DEB_CYCLES (DEB),
      .SCAN_DIV   (SCAN_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_seg   (char_seg),
      .char_ready (char_ready),
      .bksp_btn   (bksp_btn),
      .clr_btn    (clr_btn),
      .seg_buf    (seg_buf),
      .count      (count),
      .full       (full),
      .an         (an),
      .seg        (seg)
   );

   typedef struct {
      int          cyc;
      logic [63:0] buf_v;
      logic [3:0]  cnt;
      logic        full;
      logic        rdy;
      logic [7:0]  an;
      logic [7:0]  seg;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int cyc = 0;
   int n_vec = 0;
   int n_miss = 0;

   logic [63:0] m_buf;
   logic [3:0]  m_cnt;
   int          cmd_edge;
   bit          cmd_clr;
   int          edges;
   bit          in_reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         check_eq("seg_buf", seg_buf, mon_e.buf_v);
         check_eq("count", 64'(count), 64'(mon_e.cnt));
         check_eq("full", 64'(full), 64'(mon_e.full));
         check_eq("char_ready", 64'(char_ready), 64'(mon_e.rdy));
         check_eq("an", 64'(an), 64'(mon_e.an));
         check_eq("seg", 64'(seg), 64'(mon_e.seg));
      end
   end

   // Predict the state after the coming edge from current inputs, queue it, then advance one cycle.
   task automatic tick();
      int          k;
      int          idx;
      exp_t        e;
      logic [63:0] pre;
      k = cyc + 1;
      e.an  = 8'hFF;
      e.seg = 8'h00;
      if (in_reset) begin
         m_buf = '0;
         m_cnt = '0;
      end else begin
         pre = m_buf;
         if (k == cmd_edge) begin
            if (cmd_clr) begin
               m_buf = '0;
               m_cnt = '0;
            end else if (m_cnt != 0) begin
               m_buf = {8'h00, m_buf[63:8]};
               m_cnt = m_cnt - 4'd1;
            end
         end else if (char_valid && char_seg != 8'h00) begin
            m_buf = {m_buf[55:0], char_seg};
            if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
         end
         edges++;
`ifdef DISP_SCAN_EN
         idx   = ((edges - 1) / SCAN_DIV) % 8;
         e.an  = ~(8'h01 << idx);
         e.seg = pre[idx*8 +: 8];
`else
         idx = 0;
`endif
      end
      e.cyc   = k;
      e.buf_v = m_buf;
      e.cnt   = m_cnt;
      e.full  = (m_cnt == 4'd8);
      e.rdy   = in_reset ? 1'b1 : (k != cmd_edge - 1);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic push_char(input logic [7:0] s);
      char_valid = 1'b1;
      char_seg   = s;
      tick();
   endtask

   // Raw edge at drive cycle c: 2 sync + DEB samples -> pulse -> flag (ready low at c+7) -> execute at edge c+8.
   task automatic press(input bit b, input bit c, input int hold, input bit fires);
      cmd_edge = fires ? cyc + 3 + DEB + 1 : -1;
      cmd_clr  = c;
      bksp_btn = b;
      clr_btn  = c;
      repeat (hold) tick();
      bksp_btn = 1'b0;
      clr_btn  = 1'b0;
      repeat (12) tick();
   endtask

   initial begin
      rst        = 1'b0;
      char_valid = 1'b0;
      char_seg   = 8'h00;
      bksp_btn   = 1'b0;
      clr_btn    = 1'b0;
      m_buf      = '0;
      m_cnt      = '0;
      cmd_edge   = -1;
      cmd_clr    = 1'b0;
      edges      = 0;
      in_reset   = 1'b1;
      repeat (3) tick();
      rst      = 1'b1;
      in_reset = 1'b0;
      edges    = 0;
      repeat (2) tick();

      push_char(8'h77);
      push_char(8'h7C);
      push_char(8'h39);
      char_valid = 1'b0;
      tick();
      check_eq("tp_three_buf", seg_buf, 64'h0000_0000_0077_7C39);
      check_eq("tp_three_cnt", 64'(count), 64'd3);

      press(1'b1, 1'b0, 6, 1'b1);
      check_eq("tp_bksp_buf", seg_buf, 64'h0000_0000_0000_777C);
      check_eq("tp_bksp_cnt", 64'(count), 64'd2);

      press(1'b0, 1'b1, 6, 1'b1);
      check_eq("tp_clr_buf", seg_buf, 64'h0);
      press(1'b1, 1'b0, 6, 1'b1);
      check_eq("tp_bksp_empty_cnt", 64'(count), 64'd0);

      for (int i = 1; i <= 9; i++) push_char(8'(i));
      char_valid = 1'b0;
      tick();
      check_eq("tp_scroll_buf", seg_buf, 64'h0203_0405_0607_0809);
      check_eq("tp_scroll_full", 64'(full), 64'd1);

      press(1'b1, 1'b0, 3, 1'b0);
      check_eq("tp_glitch_buf", seg_buf, 64'h0203_0405_0607_0809);
      press(1'b1, 1'b0, 6, 1'b1);
      check_eq("tp_held_buf", seg_buf, 64'h0002_0304_0506_0708);
      check_eq("tp_held_cnt", 64'(count), 64'd7);

      push_char(8'h00);
      char_valid = 1'b0;
      tick();
      check_eq("tp_zero_buf", seg_buf, 64'h0002_0304_0506_0708);
      repeat (20) tick();

      char_valid = 1'b1;
      char_seg   = 8'h55;
      press(1'b1, 1'b1, 6, 1'b1);
      char_valid = 1'b0;
      repeat (4) tick();

      @(negedge clk);
      #1;
      rst      = 1'b0;
      in_reset = 1'b1;
      m_buf    = '0;
      m_cnt    = '0;
      cmd_edge = -1;
      #1;
      check_eq("arst_an", 64'(an), 64'hFF);
      check_eq("arst_seg", 64'(seg), 64'h00);
      check_eq("arst_buf", seg_buf, 64'h0);
      repeat (2) tick();
      rst      = 1'b1;
      in_reset = 1'b0;
      edges    = 0;
      push_char(8'h3F);
      char_valid = 1'b0;
      repeat (20) tick();

      @(negedge clk);
      #1;
      check_eq("sb_drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
